mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 6, memory block-address width.
REQ-002 Parameter: DATA_W, 32, memory block data width.
REQ-003 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-004 RESET  in  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-005 dc_read / dc_write  in  1 each  data-cache read/write request.
REQ-006 dc_address  in  ADDR_W  data-cache block address.
REQ-007 dc_writedata  in  DATA_W  data-cache write-back block.
REQ-008 dc_readdata  out  DATA_W  block returned to data cache.
REQ-009 dc_busywait  out  1  stall to data cache.
REQ-010 ic_read  in  1  instruction-cache read request (read-only client).
REQ-011 ic_address  in  ADDR_W  instruction-cache block address.
REQ-012 ic_readdata  out  DATA_W  block returned to instruction cache.
REQ-013 ic_busywait  out  1  stall to instruction cache.
REQ-014 mem_read / mem_write  out  1 each  request to shared main memory.
REQ-015 mem_address  out  ADDR_W; mem_writedata  out  DATA_W  forwarded request fields.
REQ-016 mem_readdata  in  DATA_W; mem_busywait  in  1  memory response and stall.
REQ-017 dc_count / ic_count  out  16 each  completed-transaction counters per client.

Function
REQ-018 States: IDLE, GRANT_D, GRANT_I; state, last_grant (1 bit: D/I), seen_busy flag and both counters are registers.
REQ-019 In IDLE, mem_read=mem_write=0, mem_address/mem_writedata=0.
REQ-020 Client requests: dreq = dc_read|dc_write; ireq = ic_read.
REQ-021 IDLE->GRANT_D when dreq and mem_busywait=0, and either ireq=0 or last_grant=I.
REQ-022 IDLE->GRANT_I when ireq and mem_busywait=0, and either dreq=0 or last_grant=D.
REQ-023 In IDLE with mem_busywait=1, no grant; stay IDLE, even if requests are pending.
REQ-024 In GRANT_D, dc_read/dc_write/dc_address/dc_writedata are forwarded combinationally to the mem_* outputs.
REQ-025 If dc_read and dc_write are both 1, mem_write=1 and mem_read=0.
REQ-026 In GRANT_I, mem_read=ic_read, mem_address=ic_address, mem_write=0, mem_writedata=0.
REQ-027 seen_busy is cleared on grant entry and set on any cycle in a GRANT state with mem_busywait=1.
REQ-028 done = (GRANT state) & seen_busy & !mem_busywait.
REQ-029 On the posedge where done=1: return to IDLE, set last_grant to the served client, clear seen_busy, and increment that client's counter, saturating at 16'hFFFF.
REQ-030 If the granted client drops its request before done, return to IDLE next edge without counting.
REQ-031 Minimum one IDLE cycle between consecutive grants, so the memory always sees the request deassert.
REQ-032 dc_busywait = dreq & !(state==GRANT_D & done), combinational.
REQ-033 ic_busywait = ireq & !(state==GRANT_I & done), combinational.
REQ-034 dc_readdata and ic_readdata are driven by mem_readdata at all times; the data is valid to a client only in its done cycle.
REQ-035 A non-granted requesting client sees busywait=1 for the entire other grant.

Reset
REQ-036 On RESET at posedge: state=IDLE, last_grant=I (data cache wins the first tie), seen_busy=0, dc_count=ic_count=0.
REQ-037 Reset applied mid-grant abandons the transfer: mem_read/mem_write are 0 from the next cycle, and no counter increments.
REQ-038 RESET has priority over done on the same edge.

Verification
REQ-039 Single dc read: memory busy for 5 cycles, returns 32'hDEADBEEF -> mem_read=1 with mem_address=dc_address; dc_busywait falls in the done cycle with dc_readdata=32'hDEADBEEF; dc_count=1.
REQ-040 Simultaneous dc_read and ic_read after reset -> GRANT_D first; after completion, one IDLE cycle, then GRANT_I; ic_busywait stays 1 throughout the D grant.
REQ-041 Both clients requesting continuously for 4 transactions -> grants alternate D, I, D, I; dc_count=ic_count=2.
REQ-042 dc_write with dc_writedata=32'h12345678, address 6'h2A -> mem_write=1, mem_writedata=32'h12345678, mem_address=6'h2A; mem_read=0.
REQ-043 RESET asserted 2 cycles into a GRANT_I -> next cycle IDLE with mem_read=0 and ic_count=0; a new request is not granted until mem_busywait=0.
REQ-044 Preload dc_count=16'hFFFE via transactions or force, then run 3 dc transactions -> dc_count holds at 16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus bundle: data-cache, instruction-cache
// and main-memory signals grouped for the arbiter and its environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              dc_read;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_address;
  logic [DATA_W-1:0] dc_writedata;
  logic [DATA_W-1:0] dc_readdata;
  logic              dc_busywait;

  logic              ic_read;
  logic [ADDR_W-1:0] ic_address;
  logic [DATA_W-1:0] ic_readdata;
  logic              ic_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  logic [15:0]       dc_count;
  logic [15:0]       ic_count;

  modport slave (
    input  dc_read, dc_write, dc_address, dc_writedata,
    output dc_readdata, dc_busywait,
    input  ic_read, ic_address,
    output ic_readdata, ic_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait,
    output dc_count, ic_count
  );

  modport master (
    output dc_read, dc_write, dc_address, dc_writedata,
    input  dc_readdata, dc_busywait,
    output ic_read, ic_address,
    input  ic_readdata, ic_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait,
    input  dc_count, ic_count
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the
// data cache and the instruction cache, with per-client counters.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_i_q, last_i_d;
  logic        seen_busy_q, seen_busy_d;
  logic [15:0] dc_count_q, dc_count_d;
  logic [15:0] ic_count_q, ic_count_d;

  logic dreq;
  logic ireq;
  logic in_grant;
  logic done;
  logic grant_d_ok;
  logic grant_i_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

  assign dreq     = bus.dc_read | bus.dc_write;
  assign ireq     = bus.ic_read;
  assign in_grant = (state_q == GRANT_D) | (state_q == GRANT_I);
  assign done     = in_grant & seen_busy_q & ~bus.mem_busywait;

  // last_i_q=1 means the instruction cache was served last, so D wins ties
  assign grant_d_ok = dreq & (~ireq | last_i_q);
  assign grant_i_ok = ireq & (~dreq | ~last_i_q);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      last_i_q    <= 1'b1;
      seen_busy_q <= 1'b0;
      dc_count_q  <= 16'd0;
      ic_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      last_i_q    <= last_i_d;
      seen_busy_q <= seen_busy_d;
      dc_count_q  <= dc_count_d;
      ic_count_q  <= ic_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_i_d    = last_i_q;
    seen_busy_d = seen_busy_q;
    dc_count_d  = dc_count_q;
    ic_count_d  = ic_count_q;
    unique case (state_q)
      IDLE: begin
        seen_busy_d = 1'b0;
        if (!bus.mem_busywait) begin
          unique case (1'b1)
            grant_d_ok: state_d = GRANT_D;
            grant_i_ok: state_d = GRANT_I;
            default:    state_d = IDLE;
          endcase
        end
      end
      GRANT_D: begin
        if (bus.mem_busywait) seen_busy_d = 1'b1;
        if (done) begin
          state_d     = IDLE;
          last_i_d    = 1'b0;
          seen_busy_d = 1'b0;
          dc_count_d  = sat_inc(dc_count_q);
        end else if (!dreq) begin
          state_d     = IDLE;
          seen_busy_d = 1'b0;
        end
      end
      GRANT_I: begin
        if (bus.mem_busywait) seen_busy_d = 1'b1;
        if (done) begin
          state_d     = IDLE;
          last_i_d    = 1'b1;
          seen_busy_d = 1'b0;
          ic_count_d  = sat_inc(ic_count_q);
        end else if (!ireq) begin
          state_d     = IDLE;
          seen_busy_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        seen_busy_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = {ADDR_W{1'b0}};
    bus.mem_writedata = {DATA_W{1'b0}};
    unique case (state_q)
      GRANT_D: begin
        // a simultaneous read+write is treated as a write-back
        bus.mem_write     = bus.dc_write;
        bus.mem_read      = bus.dc_read & ~bus.dc_write;
        bus.mem_address   = bus.dc_address;
        bus.mem_writedata = bus.dc_writedata;
      end
      GRANT_I: begin
        bus.mem_read    = bus.ic_read;
        bus.mem_address = bus.ic_address;
      end
      default: begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
      end
    endcase
    bus.dc_busywait = dreq & ~((state_q == GRANT_D) & done);
    bus.ic_busywait = ireq & ~((state_q == GRANT_I) & done);
    bus.dc_readdata = bus.mem_readdata;
    bus.ic_readdata = bus.mem_readdata;
    bus.dc_count    = dc_count_q;
    bus.ic_count    = ic_count_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory responder
// and immediate-assertion checks sampled on the falling clock edge.
module tb_mem_arbiter;

  localparam int LAT = 5;

  logic clk;
  logic rst;
  logic mbusy;
  logic hold_busy;
  logic [31:0] rdata;
  logic [1:0] ph;
  int cnt;
  int checks;
  int errors;

  mem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_busywait = mbusy | hold_busy;
  assign bus.mem_readdata = rdata;

  // memory: busy for LAT cycles starting the cycle after a request appears
  initial begin
    mbusy = 1'b0;
    ph    = 2'd0;
    cnt   = 0;
  end
  always @(posedge clk) begin
    if (!(bus.mem_read | bus.mem_write)) begin
      mbusy <= 1'b0;
      ph    <= 2'd0;
    end else begin
      case (ph)
        2'd0: begin
          mbusy <= 1'b1;
          cnt   <= LAT - 1;
          ph    <= 2'd1;
        end
        2'd1: begin
          if (cnt == 0) begin
            mbusy <= 1'b0;
            ph    <= 2'd2;
          end else begin
            cnt <= cnt - 1;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_free(input bit is_i, input string tag);
    logic bw;
    bw = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bw = is_i ? bus.ic_busywait : bus.dc_busywait;
      if (!bw) break;
    end
    chk({tag, "_done"}, 32'(bw), 32'd0);
  endtask

  initial begin
    logic ic_low;
    logic bw_d;
    logic bw_i;
    logic [3:0] seq;
    logic idle_bad;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    hold_busy = 1'b0;
    rdata = 32'h0;
    bus.dc_read = 1'b0;
    bus.dc_write = 1'b0;
    bus.dc_address = 6'h0;
    bus.dc_writedata = 32'h0;
    bus.ic_read = 1'b0;
    bus.ic_address = 6'h0;
    do_reset();
    @(negedge clk);

    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_dc_count", 32'(bus.dc_count), 32'd0);
    chk("rst_ic_count", 32'(bus.ic_count), 32'd0);
    chk("rst_dc_bw", 32'(bus.dc_busywait), 32'd0);

    // single dc read
    rdata = 32'hDEADBEEF;
    bus.dc_read = 1'b1;
    bus.dc_address = 6'h15;
    @(negedge clk);
    chk("d1_mem_read", 32'(bus.mem_read), 32'd1);
    chk("d1_mem_addr", 32'(bus.mem_address), 32'h15);
    chk("d1_dc_bw", 32'(bus.dc_busywait), 32'd1);
    wait_free(1'b0, "d1");
    chk("d1_rdata", bus.dc_readdata, 32'hDEADBEEF);
    bus.dc_read = 1'b0;
    @(negedge clk);
    chk("d1_count", 32'(bus.dc_count), 32'd1);
    chk("d1_idle_read", 32'(bus.mem_read), 32'd0);

    // tie after reset: D first, then I after one idle cycle
    do_reset();
    bus.dc_read = 1'b1;
    bus.dc_address = 6'h11;
    bus.ic_read = 1'b1;
    bus.ic_address = 6'h22;
    ic_low = 1'b0;
    bw_d = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) chk("t_first_addr", 32'(bus.mem_address), 32'h11);
      if (!bus.ic_busywait) ic_low = 1'b1;
      bw_d = bus.dc_busywait;
      if (!bw_d) break;
    end
    chk("t_d_done", 32'(bw_d), 32'd0);
    chk("t_ic_stall", 32'(ic_low), 32'd0);
    bus.dc_read = 1'b0;
    @(negedge clk);
    chk("t_gap_read", 32'(bus.mem_read), 32'd0);
    chk("t_gap_ic_bw", 32'(bus.ic_busywait), 32'd1);
    @(negedge clk);
    chk("t_i_read", 32'(bus.mem_read), 32'd1);
    chk("t_i_addr", 32'(bus.mem_address), 32'h22);
    wait_free(1'b1, "t_i");
    bus.ic_read = 1'b0;
    @(negedge clk);
    chk("t_ic_count", 32'(bus.ic_count), 32'd1);
    chk("t_dc_count", 32'(bus.dc_count), 32'd1);

    // continuous requests alternate D, I, D, I
    do_reset();
    bus.dc_read = 1'b1;
    bus.ic_read = 1'b1;
    seq = 4'h0;
    idle_bad = 1'b0;
    for (int t = 0; t < 4; t++) begin
      bw_d = 1'b1;
      bw_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        bw_d = bus.dc_busywait;
        bw_i = bus.ic_busywait;
        if (!bw_d || !bw_i) break;
      end
      seq = {seq[2:0], bw_d};
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) idle_bad = 1'b1;
    end
    chk("rr_order", 32'(seq), 32'h5);
    chk("rr_idle_gap", 32'(idle_bad), 32'd0);
    chk("rr_dc_count", 32'(bus.dc_count), 32'd2);
    chk("rr_ic_count", 32'(bus.ic_count), 32'd2);
    bus.dc_read = 1'b0;
    bus.ic_read = 1'b0;

    // write-back, then read+write collapsing to a write
    do_reset();
    bus.dc_write = 1'b1;
    bus.dc_address = 6'h2A;
    bus.dc_writedata = 32'h12345678;
    @(negedge clk);
    chk("w_mem_write", 32'(bus.mem_write), 32'd1);
    chk("w_mem_read", 32'(bus.mem_read), 32'd0);
    chk("w_mem_addr", 32'(bus.mem_address), 32'h2A);
    chk("w_mem_wdata", bus.mem_writedata, 32'h12345678);
    bus.dc_read = 1'b1;
    @(negedge clk);
    chk("rw_mem_write", 32'(bus.mem_write), 32'd1);
    chk("rw_mem_read", 32'(bus.mem_read), 32'd0);
    wait_free(1'b0, "w");
    bus.dc_read = 1'b0;
    bus.dc_write = 1'b0;
    @(negedge clk);
    chk("w_count", 32'(bus.dc_count), 32'd1);

    // reset two cycles into an I grant
    do_reset();
    bus.ic_read = 1'b1;
    bus.ic_address = 6'h07;
    @(negedge clk);
    chk("ri_read", 32'(bus.mem_read), 32'd1);
    chk("ri_addr", 32'(bus.mem_address), 32'h07);
    @(negedge clk);
    rst = 1'b1;
    hold_busy = 1'b1;
    @(negedge clk);
    chk("ri_rst_read", 32'(bus.mem_read), 32'd0);
    chk("ri_rst_count", 32'(bus.ic_count), 32'd0);
    chk("ri_rst_bw", 32'(bus.ic_busywait), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ri_hold_read", 32'(bus.mem_read), 32'd0);
    hold_busy = 1'b0;
    @(negedge clk);
    chk("ri_regrant", 32'(bus.mem_read), 32'd1);
    wait_free(1'b1, "ri");
    bus.ic_read = 1'b0;
    @(negedge clk);
    chk("ri_count", 32'(bus.ic_count), 32'd1);

    // reset on the same edge as done wins
    do_reset();
    bus.dc_read = 1'b1;
    wait_free(1'b0, "rd");
    rst = 1'b1;
    @(negedge clk);
    chk("rd_count", 32'(bus.dc_count), 32'd0);
    chk("rd_read", 32'(bus.mem_read), 32'd0);
    rst = 1'b0;
    bus.dc_read = 1'b0;
    @(negedge clk);

    // counter saturation
    do_reset();
    force dut.dc_count_q = 16'hFFFE;
    #1;
    release dut.dc_count_q;
    #1;
    chk("sat_preload", 32'(bus.dc_count), 32'hFFFE);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      bus.dc_read = 1'b1;
      wait_free(1'b0, "sat");
      bus.dc_read = 1'b0;
      @(negedge clk);
      chk("sat_count", 32'(bus.dc_count), 32'hFFFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
